// File: rtl/debounce_pkg.sv
// Shared constants, width helper and per-channel flag bundle for the
// push-button conditioning bank.
package debounce_pkg;

    localparam int unsigned DB_STABLE_CNT_50MHZ = 1_000_000;   // 20 ms at 50 MHz
    localparam int unsigned DB_LONG_CNT_50MHZ   = 50_000_000;  // 1 s at 50 MHz

    // Counter width for a maximum value of v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic long_pulse;
        logic long_level;
    } ch_flags_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, stable-count debounce, edge strobes
// and optional long-press detection. All outputs are registered.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 5,
    parameter int unsigned LONG_CNT   = 0,
    parameter bit          INVERT     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    input  logic en_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_pulse_o,
    output logic long_level_o
);

    localparam int unsigned CNT_W = clog2_min1(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Synchroniser keeps running regardless of the channel enable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_i ^ INVERT;
            s2_q <= s1_q;
        end
    end

    // Any agreeing sample restarts the count; no partial credit survives a bounce.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!en_i) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = s2_q;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

    if (LONG_CNT > 0) begin : g_long
        localparam int unsigned LONG_W = clog2_min1(LONG_CNT + 1);
        localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CNT);

        logic [LONG_W-1:0] lcnt_q, lcnt_d;
        logic              lpulse_q, lpulse_d;
        logic              llevel_q, llevel_d;

        // Hold counter saturates; the release edge clears it alongside fall_o.
        always_comb begin
            lcnt_d   = lcnt_q;
            llevel_d = llevel_q;
            lpulse_d = 1'b0;
            if (!en_i || fall_d) begin
                lcnt_d   = '0;
                llevel_d = 1'b0;
            end else if (level_q && (lcnt_q != LONG_MAX)) begin
                lcnt_d = lcnt_q + LONG_W'(1);
                if (lcnt_q == LONG_MAX - LONG_W'(1)) begin
                    lpulse_d = 1'b1;
                    llevel_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                lcnt_q   <= '0;
                lpulse_q <= 1'b0;
                llevel_q <= 1'b0;
            end else begin
                lcnt_q   <= lcnt_d;
                lpulse_q <= lpulse_d;
                llevel_q <= llevel_d;
            end
        end

        assign long_pulse_o = lpulse_q;
        assign long_level_o = llevel_q;
    end else begin : g_no_long
        assign long_pulse_o = 1'b0;
        assign long_level_o = 1'b0;
    end

endmodule

// File: rtl/debounce_bank.sv
// N independent debounced button channels between board pins and control logic.
// Counter widths are derived inside each channel from STABLE_CNT / LONG_CNT.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned STABLE_CNT = 5,
    parameter int unsigned LONG_CNT   = 0,
    parameter bit          INVERT     = 1'b0
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] db_level,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] long_pulse,
    output logic [NUM_CH-1:0] long_level
);

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        ch_flags_t flags;

        debounce_channel #(
            .STABLE_CNT (STABLE_CNT),
            .LONG_CNT   (LONG_CNT),
            .INVERT     (INVERT)
        ) u_ch (
            .clk_i        (clk_50MHz),
            .rst_ni       (reset),
            .btn_i        (btn_in[i]),
            .en_i         (ch_en[i]),
            .level_o      (flags.level),
            .rise_o       (flags.rise),
            .fall_o       (flags.fall),
            .long_pulse_o (flags.long_pulse),
            .long_level_o (flags.long_level)
        );

        assign db_level[i]   = flags.level;
        assign rise_pulse[i] = flags.rise;
        assign fall_pulse[i] = flags.fall;
        assign long_pulse[i] = flags.long_pulse;
        assign long_level[i] = flags.long_level;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: two instances (active-high with long-press, active-low
// without), directed latency scenarios, then randomized pins/enables/resets.
module tb_debounce_bank;

    localparam int unsigned NCH    = 4;
    localparam int unsigned STABLE = 5;
    localparam int unsigned LONG_A = 20;

    logic            clk_50MHz = 1'b0;
    logic            reset;
    logic [NCH-1:0]  pins [2];
    logic [NCH-1:0]  en   [2];
    logic [NCH-1:0]  lvl_a, rise_a, fall_a, lp_a, ll_a;
    logic [NCH-1:0]  lvl_b, rise_b, fall_b, lp_b, ll_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: sync history, disagreement run length, held-cycle count.
    bit             m_s1   [2][NCH];
    bit             m_s2   [2][NCH];
    int             m_run  [2][NCH];
    bit             m_lvl  [2][NCH];
    int             m_held [2][NCH];
    bit             m_llvl [2][NCH];
    logic [NCH-1:0] e_lvl [2], e_rise [2], e_fall [2], e_lp [2], e_ll [2];

    always #10 clk_50MHz = ~clk_50MHz;

    debounce_bank #(.NUM_CH(NCH), .STABLE_CNT(STABLE), .LONG_CNT(LONG_A), .INVERT(1'b0)) u_dut_a (
        .clk_50MHz (clk_50MHz), .reset (reset), .btn_in (pins[0]), .ch_en (en[0]),
        .db_level (lvl_a), .rise_pulse (rise_a), .fall_pulse (fall_a),
        .long_pulse (lp_a), .long_level (ll_a)
    );

    debounce_bank #(.NUM_CH(NCH), .STABLE_CNT(STABLE), .LONG_CNT(0), .INVERT(1'b1)) u_dut_b (
        .clk_50MHz (clk_50MHz), .reset (reset), .btn_in (pins[1]), .ch_en (en[1]),
        .db_level (lvl_b), .rise_pulse (rise_b), .fall_pulse (fall_b),
        .long_pulse (lp_b), .long_level (ll_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference by one rising edge using the inputs present at that edge.
    task automatic model_edge(input int u, input bit inv, input int long_cnt);
        bit synced, was;
        for (int c = 0; c < int'(NCH); c++) begin
            e_rise[u][c] = 1'b0;
            e_fall[u][c] = 1'b0;
            e_lp[u][c]   = 1'b0;
            if (!reset) begin
                m_s1[u][c] = 0; m_s2[u][c] = 0; m_run[u][c] = 0;
                m_lvl[u][c] = 0; m_held[u][c] = 0; m_llvl[u][c] = 0;
            end else begin
                synced     = m_s2[u][c];
                m_s2[u][c] = m_s1[u][c];
                m_s1[u][c] = pins[u][c] ^ inv;
                was        = m_lvl[u][c];
                if (!en[u][c]) begin
                    m_run[u][c] = 0; m_lvl[u][c] = 0; m_held[u][c] = 0; m_llvl[u][c] = 0;
                end else begin
                    if (synced == m_lvl[u][c]) begin
                        m_run[u][c] = 0;
                    end else begin
                        m_run[u][c]++;
                        if (m_run[u][c] == int'(STABLE)) begin
                            m_run[u][c] = 0;
                            m_lvl[u][c] = synced;
                            e_rise[u][c] = synced;
                            e_fall[u][c] = !synced;
                        end
                    end
                    if (was && !m_lvl[u][c]) begin
                        m_held[u][c] = 0;
                        m_llvl[u][c] = 0;
                    end else if (was && long_cnt > 0 && m_held[u][c] < long_cnt) begin
                        m_held[u][c]++;
                        if (m_held[u][c] == long_cnt) begin
                            e_lp[u][c]   = 1'b1;
                            m_llvl[u][c] = 1'b1;
                        end
                    end
                end
            end
            e_lvl[u][c] = m_lvl[u][c];
            e_ll[u][c]  = m_llvl[u][c];
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        model_edge(0, 1'b0, int'(LONG_A));
        model_edge(1, 1'b1, 0);
        #1;
        check("a.db_level",   32'(lvl_a),  32'(e_lvl[0]));
        check("a.rise_pulse", 32'(rise_a), 32'(e_rise[0]));
        check("a.fall_pulse", 32'(fall_a), 32'(e_fall[0]));
        check("a.long_pulse", 32'(lp_a),   32'(e_lp[0]));
        check("a.long_level", 32'(ll_a),   32'(e_ll[0]));
        check("b.db_level",   32'(lvl_b),  32'(e_lvl[1]));
        check("b.rise_pulse", 32'(rise_b), 32'(e_rise[1]));
        check("b.fall_pulse", 32'(fall_b), 32'(e_fall[1]));
        check("b.long_pulse", 32'(lp_b),   32'(e_lp[1]));
        check("b.long_level", 32'(ll_b),   32'(e_ll[1]));
    endtask

    int tmr [2][NCH];
    int n;
    int rst_hold;

    initial begin
        reset   = 1'b0;
        pins[0] = '0;
        pins[1] = '1;
        en[0]   = '1;
        en[1]   = '1;
        repeat (3) step();
        reset = 1'b1;
        repeat (4) step();

        // Clean step on a[0]: first sampling edge is step 1, level at step STABLE+2.
        pins[0][0] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!lvl_a[0] && n < 30);
        check("lat_step_a0", 32'(n), 32'(STABLE + 2));

        // Active-low pin on b[3].
        pins[1][3] = 1'b0;
        n = 0;
        do begin step(); n++; end while (!lvl_b[3] && n < 30);
        check("lat_invert_b3", 32'(n), 32'(STABLE + 2));

        // Disable while pressed, then re-enable with the pin still held.
        en[0][0] = 1'b0;
        step();
        check("dis_level_a0", 32'(lvl_a[0]), 32'd0);
        check("dis_fall_a0",  32'(fall_a[0]), 32'd0);
        en[0][0] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!rise_a[0] && n < 30);
        check("lat_reenable_a0", 32'(n), 32'(STABLE));

        // Reset partway through a count on a[1].
        pins[0][1] = 1'b1;
        repeat (5) step();
        reset = 1'b0;
        repeat (2) step();
        check("rst_level_a", 32'(lvl_a), 32'd0);
        reset = 1'b1;
        n = 0;
        do begin step(); n++; end while (!rise_a[1] && n < 30);
        check("lat_after_reset_a1", 32'(n), 32'(STABLE + 2));

        // Hold a[1] for the long-press interval, then release.
        n = 0;
        do begin step(); n++; end while (!lp_a[1] && n < 60);
        check("lat_long_a1", 32'(n), 32'(LONG_A));
        pins[0][1] = 1'b0;
        n = 0;
        do begin step(); n++; end while (!fall_a[1] && n < 30);
        check("long_level_drop_a1", 32'(ll_a[1]), 32'd0);

        // Randomized bouncing / holds, occasional disables and resets.
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < int'(NCH); c++) tmr[u][c] = 0;
        rst_hold = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int u = 0; u < 2; u++) begin
                for (int c = 0; c < int'(NCH); c++) begin
                    if (tmr[u][c] == 0) begin
                        pins[u][c] = ~pins[u][c];
                        tmr[u][c]  = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 7))
                                                                 : int'($urandom_range(8, 45));
                    end else begin
                        tmr[u][c]--;
                    end
                    if ($urandom_range(0, 299) == 0) en[u][c] = ~en[u][c];
                    else if (!en[u][c] && $urandom_range(0, 19) == 0) en[u][c] = 1'b1;
                end
            end
            if (rst_hold > 0) begin
                rst_hold--;
                reset = (rst_hold == 0);
            end else if ($urandom_range(0, 799) == 0) begin
                rst_hold = int'($urandom_range(1, 3));
                reset    = 1'b0;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Parametrised N-channel push-button conditioner, the successor to the fixed 4-button debouncer feeding the stopwatch control FSM. Per channel it does:
- 2-FF synchronisation;
- optional polarity inversion;
- stable-count debouncing;
- registered rise/fall strobes;
- long-press detection.

Replaces hand-instantiated DFF/counter chains; sits between board button pins and control logic.

Parameters:
NUM_CH, 4, number of independent button channels (>=1)
STABLE_CNT, 5, consecutive synchronised cycles of disagreement required to accept a new level (>=1)
LONG_CNT, 0, cycles db_level must stay 1 before long-press fires; 0 disables long-press logic
INVERT, 0, 1 = buttons are active-low at the pin; inversion applied before the first sync FF
CNT_W, $clog2(STABLE_CNT+1), debounce counter width (derived; do not override)
LONG_W, $clog2(LONG_CNT+1) (min 1), long-press counter width (derived)

Ports:
clk_50MHz  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
btn_in  input  NUM_CH  raw asynchronous button pins
ch_en  input  NUM_CH  per-channel enable, synchronous
db_level  output  NUM_CH  debounced logical level (1 = pressed)
rise_pulse  output  NUM_CH  1-cycle strobe on accepted 0->1
fall_pulse  output  NUM_CH  1-cycle strobe on accepted 1->0
long_pulse  output  NUM_CH  1-cycle strobe when press held LONG_CNT cycles
long_level  output  NUM_CH  1 from long_pulse until release/disable

Behaviour:
- Reset (reset==0 at a rising edge):
  - sync FFs, debounce counters, long counters and all outputs go to 0.
  - Reset mid-bounce discards partial counts.
- Sync: s1 <= btn_in[i]^INVERT; s2 <= s1. No other logic samples btn_in.
- Debounce, evaluated per cycle when ch_en[i]=1:
  - s2==db_level: cnt<=0.
  - s2!=db_level and cnt<STABLE_CNT-1: cnt<=cnt+1.
  - s2!=db_level and cnt==STABLE_CNT-1: db_level<=s2, cnt<=0, and the matching rise_pulse/fall_pulse is high for exactly this one cycle, registered on the same edge as db_level.
- Latency: a clean pin step sampled at edge k gives a db_level change at edge k+STABLE_CNT+1 (STABLE_CNT+2 edges inclusive).
- Bounce: any single cycle of s2 agreeing with db_level clears cnt. Counting restarts; no partial credit.
- A glitch shorter than STABLE_CNT synchronised cycles never changes db_level or pulses.
- Long press (LONG_CNT>0):
  - lcnt increments while db_level=1, saturating at LONG_CNT.
  - long_pulse is high for one cycle on the edge lcnt reaches LONG_CNT; long_level<=1 on that same edge.
  - When db_level falls: lcnt<=0 and long_level<=0 on the same edge as fall_pulse.
  - A release before LONG_CNT produces no long_pulse.
- LONG_CNT=0: long_pulse/long_level tied 0, no counter generated.
- ch_en[i]=0:
  - db_level, cnt, lcnt, long_level and all pulses for that channel are forced to 0 on the next edge.
  - No fall_pulse is emitted on disable.
  - Sync FFs keep running.
- Re-enable with button held: normal debounce from db_level=0, so rise_pulse arrives STABLE_CNT edges after ch_en rises.
- Channels are fully independent. Simultaneous events on several channels give simultaneous pulses, with no arbitration.
- Pulses never overlap on one channel: rise and fall need at least STABLE_CNT cycles between them.

Decomposition:
- Shared package (debounce_pkg):
  - default constants DB_STABLE_CNT_50MHZ (20 ms = 1_000_000) and DB_LONG_CNT_50MHZ (1 s = 50_000_000);
  - function clog2_min1 for width derivation.
- One sub-module, debounce_channel:
  - single-channel sync + debounce + long-press;
  - parameters STABLE_CNT/LONG_CNT/INVERT.
- debounce_bank is a generate loop over NUM_CH instances.

Test Plan:
1. NUM_CH=4, STABLE_CNT=5, clean 0->1 step on btn_in[0] sampled at edge 10 -> db_level[0]=1 and rise_pulse[0]=1 for exactly one cycle at edge 16; other channels stay 0.
2. Bounce: btn_in[1] toggles 1,0,1,0 each 3 cycles then holds 1 -> no pulse during toggling; rise_pulse[1] exactly once, STABLE_CNT+1 edges after the final settle sample.
3. LONG_CNT=20: hold btn_in[2] for 40 cycles then release -> long_pulse[2] is one cycle, 20 edges after rise_pulse[2]; long_level[2] stays high until fall_pulse[2], and both drop on the same edge.
4. INVERT=1: pins idle 1, drive btn_in[3]=0 -> db_level[3]=1 after 7 edges. Reset idle pins -> no spurious pulse after reset deasserts.
5. Assert reset=0 mid-count (cnt=3) then release with pin held 1 -> all outputs 0 during reset; rise_pulse comes a full STABLE_CNT+2 edges after release.
6. ch_en[0] cleared while db_level[0]=1 -> db_level[0]=0 next edge, no fall_pulse. Re-set ch_en with pin still 1 -> rise_pulse[0] 5 edges later.
